pipe_ctrl: RTL and testbench

Parametrised pipeline sequencer for the CPU core. It owns the run-mode FSM (STALL/LOAD/EXEC/STOP) and the execute-latency timer. It generates per-register update codes for N-1 inter-stage registers, handling stall, bubble insertion and branch-redirect flush. It also keeps saturating performance counters and supports restart after STOP. It sits in the core top and drives every pipeline register's update input plus the execute start strobe.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_ctrl_exec_timer.sv | 38 +++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: run modes and
// the 2-bit update codes driven into every inter-stage register.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_STALL = 2'd0,
      MODE_LOAD  = 2'd1,
      MODE_EXEC  = 2'd2,
      MODE_STOP  = 2'd3
   } mode_t;

   localparam logic [1:0] UPD_HOLD  = 2'b00;
   localparam logic [1:0] UPD_ADV   = 2'b01;
   localparam logic [1:0] UPD_FLUSH = 2'b10;

endpackage

// File: rtl/pipe_ctrl_exec_timer.sv
// Execute-latency timer: counts cycles of the instruction in execute and
// flags completion once the required latency is met and no IO is pending.
module exec_timer #(
   parameter int LAT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_exec,
   input  logic [LAT_W-1:0] wait_time,
   input  logic             io_busy,
   output logic             exec_done,
   output logic             e_start
);

   logic [LAT_W-1:0] latency_reg;
   logic             e_start_reg;

   assign exec_done = in_exec && (latency_reg == wait_time) && !io_busy;
   assign e_start   = e_start_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         latency_reg <= '0;
         e_start_reg <= 1'b0;
      end else if (!in_exec) begin
         latency_reg <= '0;
         e_start_reg <= 1'b0;
      end else begin
         e_start_reg <= exec_done;
         if (exec_done)
            latency_reg <= '0;
         else if (latency_reg < wait_time)
            latency_reg <= latency_reg + 1'b1;
         // otherwise latency is met and we are waiting on io_busy
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: run-mode FSM, per-register update codes for stall,
// bubble and redirect flush, and saturating performance counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int LAT_W       = 5,
   parameter int HAZ_REG     = 1,
   parameter int REDIR_FLUSH = 2,
   parameter int CNT_W       = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          aa_received,
   input  logic                          load_done,
   input  logic                          aa_sent,
   input  logic [LAT_W-1:0]              wait_time,
   input  logic                          io_busy,
   input  logic                          hazard,
   input  logic                          redirect,
   input  logic                          stop,
   input  logic                          e_valid,
   output logic [1:0]                    mode,
   output logic [2*(NUM_STAGES-1)-1:0]   upd,
   output logic                          exec_done,
   output logic                          e_start,
   output logic [CNT_W-1:0]              cycle_cnt,
   output logic [CNT_W-1:0]              retired_cnt,
   output logic [CNT_W-1:0]              stall_cnt
);

   localparam int NUM_REGS = NUM_STAGES - 1;

   mode_t            mode_reg;
   logic [CNT_W-1:0] cycle_cnt_reg;
   logic [CNT_W-1:0] retired_cnt_reg;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic             in_exec;

   assign in_exec     = (mode_reg == MODE_EXEC);
   assign mode        = mode_reg;
   assign cycle_cnt   = cycle_cnt_reg;
   assign retired_cnt = retired_cnt_reg;
   assign stall_cnt   = stall_cnt_reg;

   exec_timer #(
      .LAT_W (LAT_W)
   ) u_exec_timer (
      .clk       (clk),
      .rst       (rst),
      .in_exec   (in_exec),
      .wait_time (wait_time),
      .io_busy   (io_busy),
      .exec_done (exec_done),
      .e_start   (e_start)
   );

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Per-register codes are fixed by register position; only the select is dynamic.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_upd
         localparam logic [1:0] HAZ_CODE = (gi < HAZ_REG)  ? UPD_HOLD  :
                                           (gi == HAZ_REG) ? UPD_FLUSH : UPD_ADV;
         localparam logic [1:0] REDIR_CODE = (gi < REDIR_FLUSH) ? UPD_FLUSH : UPD_ADV;

         assign upd[2*gi +: 2] = !in_exec   ? UPD_FLUSH  :
                                 !exec_done ? UPD_HOLD   :
                                 redirect   ? REDIR_CODE :
                                 hazard     ? HAZ_CODE   : UPD_ADV;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg        <= MODE_STALL;
         cycle_cnt_reg   <= '0;
         retired_cnt_reg <= '0;
         stall_cnt_reg   <= '0;
      end else begin
         case (mode_reg)
            MODE_STALL: if (aa_received)          mode_reg <= MODE_LOAD;
            MODE_LOAD:  if (load_done && aa_sent) mode_reg <= MODE_EXEC;
            MODE_EXEC:  if (stop && exec_done)    mode_reg <= MODE_STOP;
            MODE_STOP:  if (aa_received)          mode_reg <= MODE_LOAD;
            default:                              mode_reg <= MODE_STALL;
         endcase

         // A restart from STOP keeps the statistics; only a fresh boot clears them.
         if (mode_reg == MODE_STALL && aa_received) begin
            cycle_cnt_reg   <= '0;
            retired_cnt_reg <= '0;
            stall_cnt_reg   <= '0;
         end else if (in_exec) begin
            cycle_cnt_reg <= sat_inc(cycle_cnt_reg);
            if (exec_done && e_valid)
               retired_cnt_reg <= sat_inc(retired_cnt_reg);
            if (!exec_done || hazard || redirect)
               stall_cnt_reg <= sat_inc(stall_cnt_reg);
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: boot, latency, io stall, hazard/redirect,
// stop/restart, counter saturation and reset priority.
module tb_pipe_ctrl;

   localparam int NUM_STAGES  = 4;
   localparam int LAT_W       = 5;
   localparam int HAZ_REG     = 1;
   localparam int REDIR_FLUSH = 2;
   localparam int CNT_W       = 8;

   logic             clk;
   logic             rst;
   logic             aa_received;
   logic             load_done;
   logic             aa_sent;
   logic [LAT_W-1:0] wait_time;
   logic             io_busy;
   logic             hazard;
   logic             redirect;
   logic             stop;
   logic             e_valid;
   logic [1:0]       mode;
   logic [5:0]       upd;
   logic             exec_done;
   logic             e_start;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] retired_cnt;
   logic [CNT_W-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   pipe_ctrl #(
      .NUM_STAGES  (NUM_STAGES),
      .LAT_W       (LAT_W),
      .HAZ_REG     (HAZ_REG),
      .REDIR_FLUSH (REDIR_FLUSH),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .aa_received (aa_received),
      .load_done   (load_done),
      .aa_sent     (aa_sent),
      .wait_time   (wait_time),
      .io_busy     (io_busy),
      .hazard      (hazard),
      .redirect    (redirect),
      .stop        (stop),
      .e_valid     (e_valid),
      .mode        (mode),
      .upd         (upd),
      .exec_done   (exec_done),
      .e_start     (e_start),
      .cycle_cnt   (cycle_cnt),
      .retired_cnt (retired_cnt),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
      checks++; if (upd !== 6'b101010) begin failures++; $display("FAIL reset_upd got=%b exp=101010", upd); end
      checks++; if (e_start !== 1'b0) begin failures++; $display("FAIL reset_e_start got=%b exp=0", e_start); end
      checks++; if (exec_done !== 1'b0) begin failures++; $display("FAIL reset_exec_done got=%b exp=0", exec_done); end
      checks++; if (cycle_cnt !== 8'd0 || retired_cnt !== 8'd0 || stall_cnt !== 8'd0) begin
         failures++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", cycle_cnt, retired_cnt, stall_cnt);
      end
      $display("test_reset: mode=%0d upd=%b", mode, upd);
   endtask

   task automatic test_boot();
      aa_received = 1'b1;
      tick();
      aa_received = 1'b0;
      #1;
      checks++; if (mode !== 2'd1) begin failures++; $display("FAIL boot_load_mode got=%0d exp=1", mode); end
      checks++; if (upd !== 6'b101010) begin failures++; $display("FAIL boot_load_upd got=%b exp=101010", upd); end
      wait_time = 5'd3;
      e_valid   = 1'b1;
      load_done = 1'b1;
      aa_sent   = 1'b1;
      tick();
      load_done = 1'b0;
      aa_sent   = 1'b0;
      #1;
      checks++; if (mode !== 2'd2) begin failures++; $display("FAIL boot_exec_mode got=%0d exp=2", mode); end
      $display("test_boot: mode=%0d", mode);
   endtask

   // EXEC cycles E1..E4 with wait_time=3; E5 starts the io_busy scenario.
   task automatic test_latency();
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) tick();
         #1;
         checks++; if (exec_done !== (i == 4)) begin failures++; $display("FAIL lat_done cyc=%0d got=%b exp=%b", i, exec_done, (i == 4)); end
         checks++; if (upd !== ((i == 4) ? 6'b010101 : 6'b000000)) begin
            failures++; $display("FAIL lat_upd cyc=%0d got=%b exp=%b", i, upd, ((i == 4) ? 6'b010101 : 6'b000000));
         end
         checks++; if (e_start !== 1'b0) begin failures++; $display("FAIL lat_e_start_low cyc=%0d got=%b exp=0", i, e_start); end
      end
      tick();
      wait_time = 5'd0;
      io_busy   = 1'b1;
      #1;
      checks++; if (e_start !== 1'b1) begin failures++; $display("FAIL lat_e_start got=%b exp=1", e_start); end
      checks++; if (exec_done !== 1'b0) begin failures++; $display("FAIL busy_done cyc=5 got=%b exp=0", exec_done); end
      checks++; if (stall_cnt !== 8'd3) begin failures++; $display("FAIL lat_stall got=%0d exp=3", stall_cnt); end
      checks++; if (cycle_cnt !== 8'd4) begin failures++; $display("FAIL lat_cycle got=%0d exp=4", cycle_cnt); end
      checks++; if (retired_cnt !== 8'd1) begin failures++; $display("FAIL lat_retired got=%0d exp=1", retired_cnt); end
      $display("test_latency: done on 4th EXEC cycle, stall=%0d", stall_cnt);
   endtask

   // E5..E9 io_busy high, E10 io_busy low.
   task automatic test_io_busy();
      for (int i = 6; i <= 9; i++) begin
         tick();
         #1;
         checks++; if (exec_done !== 1'b0) begin failures++; $display("FAIL busy_done cyc=%0d got=%b exp=0", i, exec_done); end
         checks++; if (upd !== 6'b000000) begin failures++; $display("FAIL busy_upd cyc=%0d got=%b exp=000000", i, upd); end
         if (i == 6) begin
            checks++; if (e_start !== 1'b0) begin failures++; $display("FAIL busy_e_start got=%b exp=0", e_start); end
         end
      end
      tick();
      io_busy = 1'b0;
      #1;
      checks++; if (exec_done !== 1'b1) begin failures++; $display("FAIL busy_release got=%b exp=1", exec_done); end
      checks++; if (upd !== 6'b010101) begin failures++; $display("FAIL busy_release_upd got=%b exp=010101", upd); end
      checks++; if (stall_cnt !== 8'd8) begin failures++; $display("FAIL busy_stall got=%0d exp=8", stall_cnt); end
      checks++; if (cycle_cnt !== 8'd9) begin failures++; $display("FAIL busy_cycle got=%0d exp=9", cycle_cnt); end
      $display("test_io_busy: stall=%0d", stall_cnt);
   endtask

   // E11 hazard, E12 hazard+redirect (bubble), E13 hazard without done, E14 clean.
   task automatic test_hazard();
      tick();
      hazard = 1'b1;
      #1;
      checks++; if (exec_done !== 1'b1) begin failures++; $display("FAIL haz_done got=%b exp=1", exec_done); end
      checks++; if (upd !== 6'b011000) begin failures++; $display("FAIL haz_upd got=%b exp=011000", upd); end
      tick();
      redirect = 1'b1;
      e_valid  = 1'b0;
      #1;
      checks++; if (upd !== 6'b011010) begin failures++; $display("FAIL redir_upd got=%b exp=011010", upd); end
      tick();
      redirect  = 1'b0;
      e_valid   = 1'b1;
      wait_time = 5'd1;
      #1;
      checks++; if (exec_done !== 1'b0) begin failures++; $display("FAIL haz_wait_done got=%b exp=0", exec_done); end
      checks++; if (upd !== 6'b000000) begin failures++; $display("FAIL haz_wait_upd got=%b exp=000000", upd); end
      tick();
      hazard = 1'b0;
      #1;
      checks++; if (exec_done !== 1'b1 || upd !== 6'b010101) begin
         failures++; $display("FAIL haz_clean got=%b/%b exp=1/010101", exec_done, upd);
      end
      checks++; if (retired_cnt !== 8'd3) begin failures++; $display("FAIL haz_retired got=%0d exp=3", retired_cnt); end
      checks++; if (stall_cnt !== 8'd11) begin failures++; $display("FAIL haz_stall got=%0d exp=11", stall_cnt); end
      $display("test_hazard: retired=%0d stall=%0d", retired_cnt, stall_cnt);
   endtask

   task automatic test_stop_restart();
      tick();
      wait_time = 5'd0;
      stop      = 1'b1;
      #1;
      checks++; if (exec_done !== 1'b1) begin failures++; $display("FAIL stop_done got=%b exp=1", exec_done); end
      checks++; if (retired_cnt !== 8'd4 || cycle_cnt !== 8'd14) begin
         failures++; $display("FAIL pre_stop_cnt got=%0d/%0d exp=4/14", retired_cnt, cycle_cnt);
      end
      tick();
      stop = 1'b0;
      #1;
      checks++; if (mode !== 2'd3) begin failures++; $display("FAIL stop_mode got=%0d exp=3", mode); end
      checks++; if (upd !== 6'b101010) begin failures++; $display("FAIL stop_upd got=%b exp=101010", upd); end
      checks++; if (exec_done !== 1'b0) begin failures++; $display("FAIL stop_exec_done got=%b exp=0", exec_done); end
      checks++; if (retired_cnt !== 8'd5 || cycle_cnt !== 8'd15 || stall_cnt !== 8'd11) begin
         failures++; $display("FAIL stop_cnt got=%0d/%0d/%0d exp=5/15/11", retired_cnt, cycle_cnt, stall_cnt);
      end
      tick();
      #1;
      checks++; if (mode !== 2'd3) begin failures++; $display("FAIL stop_hold got=%0d exp=3", mode); end
      aa_received = 1'b1;
      tick();
      aa_received = 1'b0;
      #1;
      checks++; if (mode !== 2'd1) begin failures++; $display("FAIL restart_mode got=%0d exp=1", mode); end
      checks++; if (retired_cnt !== 8'd5 || cycle_cnt !== 8'd15) begin
         failures++; $display("FAIL restart_cnt got=%0d/%0d exp=5/15", retired_cnt, cycle_cnt);
      end
      $display("test_stop_restart: mode=%0d retired=%0d", mode, retired_cnt);
   endtask

   task automatic test_saturation_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (mode !== 2'd0) begin failures++; $display("FAIL sat_reset_mode got=%0d exp=0", mode); end
      e_valid     = 1'b0;
      wait_time   = 5'd0;
      aa_received = 1'b1;
      tick();
      aa_received = 1'b0;
      load_done   = 1'b1;
      aa_sent     = 1'b1;
      tick();
      load_done = 1'b0;
      aa_sent   = 1'b0;
      #1;
      checks++; if (mode !== 2'd2 || cycle_cnt !== 8'd0) begin
         failures++; $display("FAIL sat_entry got=%0d/%0d exp=2/0", mode, cycle_cnt);
      end
      repeat (254) tick();
      #1;
      checks++; if (cycle_cnt !== 8'd254) begin failures++; $display("FAIL sat_near got=%0d exp=254", cycle_cnt); end
      repeat (3) tick();
      #1;
      checks++; if (cycle_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", cycle_cnt); end
      checks++; if (stall_cnt !== 8'd0 || retired_cnt !== 8'd0) begin
         failures++; $display("FAIL sat_other got=%0d/%0d exp=0/0", stall_cnt, retired_cnt);
      end
      checks++; if (e_start !== 1'b1) begin failures++; $display("FAIL sat_e_start got=%b exp=1", e_start); end
      rst         = 1'b1;
      aa_received = 1'b1;
      tick();
      rst         = 1'b0;
      aa_received = 1'b0;
      #1;
      checks++; if (mode !== 2'd0 || upd !== 6'b101010) begin
         failures++; $display("FAIL rst_exec_mode got=%0d/%b exp=0/101010", mode, upd);
      end
      checks++; if (cycle_cnt !== 8'd0 || retired_cnt !== 8'd0 || stall_cnt !== 8'd0) begin
         failures++; $display("FAIL rst_exec_cnt got=%0d/%0d/%0d exp=0/0/0", cycle_cnt, retired_cnt, stall_cnt);
      end
      checks++; if (e_start !== 1'b0) begin failures++; $display("FAIL rst_exec_e_start got=%b exp=0", e_start); end
      aa_received = 1'b1;
      tick();
      aa_received = 1'b0;
      #1;
      checks++; if (mode !== 2'd1) begin failures++; $display("FAIL rst_load_pre got=%0d exp=1", mode); end
      rst       = 1'b1;
      load_done = 1'b1;
      aa_sent   = 1'b1;
      tick();
      rst       = 1'b0;
      load_done = 1'b0;
      aa_sent   = 1'b0;
      #1;
      checks++; if (mode !== 2'd0) begin failures++; $display("FAIL rst_load_mode got=%0d exp=0", mode); end
      $display("test_saturation_reset: cycle_cnt saturated, reset wins");
   endtask

   initial begin
      rst         = 1'b1;
      aa_received = 1'b0;
      load_done   = 1'b0;
      aa_sent     = 1'b0;
      wait_time   = 5'd0;
      io_busy     = 1'b0;
      hazard      = 1'b0;
      redirect    = 1'b0;
      stop        = 1'b0;
      e_valid     = 1'b0;
      test_reset();
      test_boot();
      test_latency();
      test_io_busy();
      test_hazard();
      test_stop_restart();
      test_saturation_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
